// File: rtl/payload_interleaver.sv
// Row-write / column-read block interleaver for one coded OFDM symbol (N_ROW x N_COL bits), ping-pong banked.
// Optional: define INTLV_ZERO_PAD_EN to zero-pad and emit a trailing partial symbol instead of discarding it.
module payload_interleaver #(
  parameter int N_COL  = 16,
  parameter int N_ROW  = 120,
  parameter int ADDR_W = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       di,
  input  logic       di_vld,
  output logic       dout,
  output logic       do_vld,
  output logic       sym_done,
  output logic [3:0] sym_cnt,
  output logic       ovf_err,
  output logic       busy
);

  localparam int N_CBPS = N_ROW * N_COL;
  localparam int R_W    = $clog2(N_ROW);
  localparam int C_W    = $clog2(N_COL);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CBPS - 1);
  localparam logic [ADDR_W-1:0] FULL_FILL = ADDR_W'(N_CBPS);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(N_COL);
  localparam logic [R_W-1:0]    LAST_ROW  = R_W'(N_ROW - 1);

  typedef enum logic {
    R_IDLE,
    R_READ
  } rd_state_t;

  rd_state_t state, state_n;

  logic [N_CBPS-1:0] bank_mem [2];
  logic [1:0]        full;
  logic [ADDR_W-1:0] fill [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wcnt;

  logic [R_W-1:0]    r;
  logic [C_W-1:0]    c;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] raddr;

  logic rd_en;
  logic rd_last;
  logic rd_bit;
  logic wr_ok;
  logic wr_drop;
  logic wr_close;
  logic part_end;

  // A read is issued in every R_READ cycle and also in the R_IDLE cycle that
  // sees a FULL bank; counters sit at zero in R_IDLE, so that issue is k=0.
  assign rd_en   = (state == R_READ) || full[rd_bank];
  assign rd_last = rd_en && (k == LAST_ADDR);
  assign rd_bit  = (raddr < fill[rd_bank]) ? bank_mem[rd_bank][raddr] : 1'b0;

  // The bank being freed by the final read this cycle is writable already.
  assign wr_ok    = di_vld && (!full[wr_bank] || (rd_last && (rd_bank == wr_bank)));
  assign wr_drop  = di_vld && !wr_ok;
  assign wr_close = wr_ok && (wcnt == LAST_ADDR);
  assign part_end = !di_vld && (wcnt != '0);

  assign busy = (|full) || (state == R_READ) || (wcnt != '0);

  // NOTE: bit storage has no reset; its contents are only read after a write
  // or masked by fill, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) bank_mem[wr_bank][wcnt] <= di;
  end

  // Write side: bank fill, FULL/fill bookkeeping and the overflow pulse.
  // NOTE: state registers use non-blocking assignments so every block sees
  // pre-edge values; the later FULL set below then wins over the earlier clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      fill[0] <= '0;
      fill[1] <= '0;
      wr_bank <= 1'b0;
      wcnt    <= '0;
      ovf_err <= 1'b0;
    end else begin
      ovf_err <= wr_drop;
      if (rd_last) full[rd_bank] <= 1'b0;
      if (wr_close) begin
        full[wr_bank] <= 1'b1;
        fill[wr_bank] <= FULL_FILL;
        wr_bank       <= ~wr_bank;
        wcnt          <= '0;
      end else if (wr_ok) begin
        wcnt <= wcnt + 1'b1;
      end else if (part_end) begin
`ifdef INTLV_ZERO_PAD_EN
        full[wr_bank] <= 1'b1;
        fill[wr_bank] <= wcnt;
        wr_bank       <= ~wr_bank;
`else
        ovf_err       <= 1'b1;
`endif
        wcnt <= '0;
      end
    end
  end

  // NOTE: combinational blocks assign every output a default first so no
  // path can leave a value held, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      R_IDLE:  if (full[rd_bank]) state_n = R_READ;
      R_READ:  if (rd_last) state_n = full[~rd_bank] ? R_READ : R_IDLE;
      default: state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= R_IDLE;
    else     state <= state_n;
  end

  // Column-major address walk: step by N_COL down a column, then jump to the
  // top of the next column, so no multiplier is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      r     <= '0;
      c     <= '0;
      raddr <= '0;
    end else if (rd_last) begin
      k     <= '0;
      r     <= '0;
      c     <= '0;
      raddr <= '0;
    end else if (rd_en) begin
      k <= k + 1'b1;
      if (r != LAST_ROW) begin
        r     <= r + 1'b1;
        raddr <= raddr + COL_STEP;
      end else begin
        r     <= '0;
        c     <= c + 1'b1;
        raddr <= ADDR_W'(c) + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank  <= 1'b0;
      dout     <= 1'b0;
      do_vld   <= 1'b0;
      sym_done <= 1'b0;
      sym_cnt  <= '0;
    end else begin
      dout     <= rd_en ? rd_bit : 1'b0;
      do_vld   <= rd_en;
      sym_done <= rd_last;
      if (rd_last) begin
        rd_bank <= ~rd_bank;
        sym_cnt <= sym_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_payload_interleaver.sv
// Self-checking bench for payload_interleaver: random bursts against a plain-arithmetic interleave model.
// Partial-symbol and overflow expectations follow INTLV_ZERO_PAD_EN.
`timescale 1ns/1ps
module tb_payload_interleaver;

  localparam int N_COL  = 16;
  localparam int N_ROW  = 120;
  localparam int N_CBPS = N_ROW * N_COL;

  typedef logic [N_CBPS-1:0] sym_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       di = 1'b0;
  logic       di_vld = 1'b0;
  logic       dout, do_vld, sym_done, ovf_err, busy;
  logic [3:0] sym_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int ovf_cnt  = 0;
  int last_in_cyc = 0;
  int exp_sym_cnt = 0;

  logic out_q[$];
  int   vld_cyc_q[$];
  logic stim_q[$];

  payload_interleaver #(.N_COL(N_COL), .N_ROW(N_ROW), .ADDR_W(11)) dut (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld),
    .dout(dout), .do_vld(do_vld), .sym_done(sym_done), .sym_cnt(sym_cnt),
    .ovf_err(ovf_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (do_vld) begin
        out_q.push_back(dout);
        vld_cyc_q.push_back(cyc);
      end
      if (sym_done) done_cnt <= done_cnt + 1;
      if (ovf_err)  ovf_cnt  <= ovf_cnt + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Output position k comes from row r = k%N_ROW, column c = k/N_ROW of the
  // row-written block, i.e. input index r*N_COL+c; positions past fill are 0.
  function automatic sym_t interleave(sym_t src, int fill);
    sym_t o = '0;
    for (int kk = 0; kk < N_CBPS; kk++) begin
      int idx;
      idx = (kk % N_ROW) * N_COL + kk / N_ROW;
      o[kk] = (idx < fill) ? src[idx] : 1'b0;
    end
    return o;
  endfunction

  function automatic sym_t sym_from_stim(int start, int len);
    sym_t v = '0;
    for (int i = 0; i < len; i++) v[i] = stim_q[start + i];
    return v;
  endfunction

  function automatic sym_t get_sym(int base, int s);
    sym_t v = '0;
    for (int i = 0; i < N_CBPS; i++) v[i] = out_q[base + s * N_CBPS + i];
    return v;
  endfunction

  function automatic int first_diff(sym_t a, sym_t b);
    for (int i = 0; i < N_CBPS; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic send_stim();
    foreach (stim_q[i]) begin
      @(posedge clk); #1;
      di = stim_q[i];
      di_vld = 1'b1;
      last_in_cyc = cyc;
    end
    @(posedge clk); #1;
    di = 1'b0;
    di_vld = 1'b0;
  endtask

  task automatic wait_bits(input int base, input int n, input int budget, output bit ok);
    int t = 0;
    while ((out_q.size() - base < n) && (t < budget)) begin
      @(posedge clk);
      t++;
    end
    ok = (out_q.size() - base >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int t = 0;
    @(negedge clk);
    while (((busy !== 1'b0) || (do_vld !== 1'b0)) && (t < budget)) begin
      @(negedge clk);
      t++;
    end
    ok = (busy === 1'b0) && (do_vld === 1'b0);
  endtask

  task automatic test_reset();
    bit ok;
    int base, d0;
    sym_t src, got, exp;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({dout, do_vld, sym_done, sym_cnt, ovf_err, busy} !== 9'b0)
      $display("FAIL reset_init: outputs=%b expected all zero", {dout, do_vld, sym_done, sym_cnt, ovf_err, busy});
    else n_pass++;
    @(negedge clk) rst = 1'b0;

    fill_random(N_CBPS);
    send_stim();
    base = out_q.size();
    wait_bits(base, 300, 4000, ok);
    n_total++;
    if (!ok) $display("FAIL reset_pre_read: got %0d bits expected 300 before reset", out_q.size() - base);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({dout, do_vld, sym_done, sym_cnt, ovf_err, busy} !== 9'b0)
      $display("FAIL reset_mid_read: outputs=%b expected all zero", {dout, do_vld, sym_done, sym_cnt, ovf_err, busy});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_sym_cnt = 0;

    d0 = done_cnt;
    base = out_q.size();
    fill_random(N_CBPS);
    src = sym_from_stim(0, N_CBPS);
    send_stim();
    wait_bits(base, N_CBPS, 4000, ok);
    wait_idle(4000, ok);
    exp_sym_cnt += 1;
    n_total++;
    if (out_q.size() - base != N_CBPS)
      $display("FAIL reset_after_len: got %0d bits expected %0d", out_q.size() - base, N_CBPS);
    else begin
      got = get_sym(base, 0);
      exp = interleave(src, N_CBPS);
      if (got !== exp) $display("FAIL reset_after_data: first differing bit %0d expected none", first_diff(got, exp));
      else n_pass++;
    end
    n_total++;
    if (done_cnt - d0 != 1) $display("FAIL reset_after_done: got %0d sym_done expected 1", done_cnt - d0);
    else n_pass++;
    n_total++;
    if (sym_cnt !== 4'(exp_sym_cnt)) $display("FAIL reset_after_cnt: got %0d expected %0d", sym_cnt, exp_sym_cnt % 16);
    else n_pass++;
  endtask

  task automatic test_single_one();
    int in_idx [3]  = '{17, 1919, 16};
    int out_idx [3] = '{121, 1919, 1};
    bit ok;
    int base, pos, ones;
    sym_t got;
    for (int t = 0; t < 3; t++) begin
      stim_q.delete();
      for (int i = 0; i < N_CBPS; i++) stim_q.push_back(i == in_idx[t]);
      base = out_q.size();
      send_stim();
      wait_bits(base, N_CBPS, 4000, ok);
      wait_idle(4000, ok);
      exp_sym_cnt += 1;
      n_total++;
      if (out_q.size() - base != N_CBPS) begin
        $display("FAIL single_one_len[%0d]: got %0d bits expected %0d", in_idx[t], out_q.size() - base, N_CBPS);
      end else begin
        got = get_sym(base, 0);
        pos = -1;
        ones = 0;
        for (int i = 0; i < N_CBPS; i++) if (got[i] === 1'b1) begin pos = i; ones++; end
        if (ones != 1 || pos != out_idx[t])
          $display("FAIL single_one[%0d]: got %0d ones last at %0d expected one at %0d", in_idx[t], ones, pos, out_idx[t]);
        else n_pass++;
      end
    end
    n_total++;
    if (sym_cnt !== 4'(exp_sym_cnt)) $display("FAIL single_one_cnt: got %0d expected %0d", sym_cnt, exp_sym_cnt % 16);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base, d0, o0, t1919, lat, span;
    sym_t got, exp;
    base = out_q.size();
    d0 = done_cnt;
    o0 = ovf_cnt;
    fill_random(5 * N_CBPS);
    send_stim();
    t1919 = last_in_cyc - (5 * N_CBPS - 1) + (N_CBPS - 1);
    wait_bits(base, 5 * N_CBPS, 12000, ok);
    n_total++;
    if (!ok) begin
      $display("FAIL b2b_len: got %0d bits expected %0d", out_q.size() - base, 5 * N_CBPS);
    end else begin
      n_pass++;
      lat = vld_cyc_q[base] - t1919;
      n_total++;
      if (lat != 2) $display("FAIL b2b_latency: got %0d cycles expected 2", lat);
      else n_pass++;
      span = vld_cyc_q[base + 5 * N_CBPS - 1] - vld_cyc_q[base];
      n_total++;
      if (span != 5 * N_CBPS - 1) $display("FAIL b2b_contiguous: span %0d expected %0d", span, 5 * N_CBPS - 1);
      else n_pass++;
      for (int s = 0; s < 5; s++) begin
        got = get_sym(base, s);
        exp = interleave(sym_from_stim(s * N_CBPS, N_CBPS), N_CBPS);
        n_total++;
        if (got !== exp) $display("FAIL b2b_sym[%0d]: first differing bit %0d expected none", s, first_diff(got, exp));
        else n_pass++;
      end
    end
    wait_idle(4000, ok);
    exp_sym_cnt += 5;
    n_total++;
    if (done_cnt - d0 != 5) $display("FAIL b2b_done: got %0d sym_done expected 5", done_cnt - d0);
    else n_pass++;
    n_total++;
    if (ovf_cnt - o0 != 0) $display("FAIL b2b_ovf: got %0d ovf_err expected 0", ovf_cnt - o0);
    else n_pass++;
    n_total++;
    if (sym_cnt !== 4'(exp_sym_cnt)) $display("FAIL b2b_cnt: got %0d expected %0d", sym_cnt, exp_sym_cnt % 16);
    else n_pass++;
  endtask

  task automatic test_partial();
    bit ok;
    int base, d0, o0, n_sym, n_ovf;
    sym_t got, exp;
`ifdef INTLV_ZERO_PAD_EN
    n_sym = 2;
    n_ovf = 0;
`else
    n_sym = 1;
    n_ovf = 1;
`endif
    base = out_q.size();
    d0 = done_cnt;
    o0 = ovf_cnt;
    stim_q.delete();
    for (int i = 0; i < 2000; i++) stim_q.push_back(1'b1);
    send_stim();
    wait_bits(base, n_sym * N_CBPS, 8000, ok);
    wait_idle(4000, ok);
    exp_sym_cnt += n_sym;
    n_total++;
    if (!ok) $display("FAIL partial_idle: busy=%b expected 0", busy);
    else n_pass++;
    n_total++;
    if (out_q.size() - base != n_sym * N_CBPS) begin
      $display("FAIL partial_len: got %0d bits expected %0d", out_q.size() - base, n_sym * N_CBPS);
    end else begin
      got = get_sym(base, 0);
      if (got !== '1) $display("FAIL partial_sym0: first zero-or-x bit %0d expected none", first_diff(got, '1));
      else n_pass++;
`ifdef INTLV_ZERO_PAD_EN
      exp = '0;
      for (int i = 0; i < 80; i++) exp[(i % N_COL) * N_ROW + i / N_COL] = 1'b1;
      got = get_sym(base, 1);
      n_total++;
      if (got !== exp) $display("FAIL partial_sym1: first differing bit %0d expected none", first_diff(got, exp));
      else n_pass++;
      n_total++;
      if ($countones(got) != 80) $display("FAIL partial_ones: got %0d ones expected 80", $countones(got));
      else n_pass++;
`endif
    end
    n_total++;
    if (done_cnt - d0 != n_sym) $display("FAIL partial_done: got %0d sym_done expected %0d", done_cnt - d0, n_sym);
    else n_pass++;
    n_total++;
    if (ovf_cnt - o0 != n_ovf) $display("FAIL partial_ovf: got %0d ovf_err expected %0d", ovf_cnt - o0, n_ovf);
    else n_pass++;
    n_total++;
    if (sym_cnt !== 4'(exp_sym_cnt)) $display("FAIL partial_cnt: got %0d expected %0d", sym_cnt, exp_sym_cnt % 16);
    else n_pass++;
  endtask

`ifdef INTLV_ZERO_PAD_EN
  // Burst A closes bank 0, B closes bank 1, C then targets the still-FULL bank 0
  // until its read finishes: 1908 bits drop, the last 12 land and close as a partial.
  task automatic test_overflow();
    bit ok;
    int base, d0, o0;
    sym_t src [3];
    sym_t got, exp;
    base = out_q.size();
    d0 = done_cnt;
    o0 = ovf_cnt;
    fill_random(10);
    src[0] = interleave(sym_from_stim(0, 10), 10);
    send_stim();
    fill_random(10);
    src[1] = interleave(sym_from_stim(0, 10), 10);
    send_stim();
    fill_random(N_CBPS);
    src[2] = interleave(sym_from_stim(N_CBPS - 12, 12), 12);
    send_stim();
    wait_bits(base, 3 * N_CBPS, 8000, ok);
    wait_idle(4000, ok);
    exp_sym_cnt += 3;
    n_total++;
    if (!ok) $display("FAIL ovf_idle: busy=%b expected 0", busy);
    else n_pass++;
    n_total++;
    if (ovf_cnt - o0 != N_CBPS - 12) $display("FAIL ovf_count: got %0d ovf_err expected %0d", ovf_cnt - o0, N_CBPS - 12);
    else n_pass++;
    n_total++;
    if (out_q.size() - base != 3 * N_CBPS) begin
      $display("FAIL ovf_len: got %0d bits expected %0d", out_q.size() - base, 3 * N_CBPS);
    end else begin
      n_pass++;
      for (int s = 0; s < 3; s++) begin
        got = get_sym(base, s);
        exp = src[s];
        n_total++;
        if (got !== exp) $display("FAIL ovf_sym[%0d]: first differing bit %0d expected none", s, first_diff(got, exp));
        else n_pass++;
      end
    end
    n_total++;
    if (done_cnt - d0 != 3) $display("FAIL ovf_done: got %0d sym_done expected 3", done_cnt - d0);
    else n_pass++;
    n_total++;
    if (sym_cnt !== 4'(exp_sym_cnt)) $display("FAIL ovf_cnt: got %0d expected %0d", sym_cnt, exp_sym_cnt % 16);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_one();
    test_back_to_back();
    test_partial();
`ifdef INTLV_ZERO_PAD_EN
    test_overflow();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
